// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU by two requesters; ALU_ARB_ILLEGAL_EN flags unknown functs via rsp_err
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_funct,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_funct,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       alu_select,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);
  localparam int CW = $clog2(EXEC_CYCLES + 1);
`ifdef ALU_ARB_ILLEGAL_EN
  localparam bit ILLEGAL_EN = 1'b1;
`else
  localparam bit ILLEGAL_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, id_q, grant, gid, dec_bad, skip;
  logic [2:0] dec_sel, sel_q;
  logic [5:0] funct;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0] cnt;
  assign grant = rst_n && state == IDLE && (req0_valid || req1_valid);
  assign gid = req1_valid && (!req0_valid || !last_grant);
  assign funct = gid ? req1_funct : req0_funct;
  assign req0_ready = grant && !gid;
  assign req1_ready = grant && gid;
  assign skip = ILLEGAL_EN && dec_bad;
  always_comb begin
    dec_bad = 1'b0;
    dec_sel = 3'd0;
    case (funct)
      6'h20: dec_sel = 3'd0;
      6'h22: dec_sel = 3'd1;
      6'h24: dec_sel = 3'd2;
      6'h25: dec_sel = 3'd3;
      6'h00: dec_sel = 3'd4;
      6'h02: dec_sel = 3'd5;
      6'h2A: dec_sel = 3'd6;
      default: dec_bad = 1'b1;
    endcase
  end
  assign state_nx = state == IDLE ? (grant ? (skip ? RESP : EXEC) : IDLE) :
                    state == EXEC ? (cnt == '0 ? RESP : EXEC) :
                    (rsp_ready ? IDLE : RESP);
  assign alu_select = state == EXEC ? sel_q : 3'd0;
  assign alu_a = state == EXEC ? a_q : '0;
  assign alu_b = state == EXEC ? b_q : '0;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      cnt <= '0;
      sel_q <= 3'd0;
      a_q <= '0;
      b_q <= '0;
      id_q <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        last_grant <= gid;
        id_q <= gid;
        sel_q <= dec_sel;
        a_q <= gid ? req1_a : req0_a;
        b_q <= gid ? req1_b : req0_b;
        cnt <= CW'(EXEC_CYCLES - 1);
        rsp_err <= skip;
        if (skip) begin
          rsp_id <= gid;
          rsp_data <= '0;
        end
      end else if (state == EXEC) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          rsp_id <= id_q;
          rsp_data <= alu_result;
        end
      end
    end
  end
endmodule
